gpio_debounce: RTL and testbench

Per-pin input conditioner that sits directly upstream of the gpio block's `in` port. It synchronises eight asynchronous board inputs into the `clk` domain and filters contact bounce and glitches with per-channel stability counters. It exposes a small CSR window for the filter controls and for reading the raw synchronised pins. Its `in_db` output wires straight to the gpio block's input bus.

---
 rtl/gpio_debounce_pkg.sv | 12 +
 rtl/debounce_chan.sv | 36 +++
 rtl/gpio_debounce_regs.vh | 9 +
 rtl/gpio_debounce.sv | 71 +++++++
 tb/tb_gpio_debounce.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_debounce_pkg.sv
// gpio_debounce_pkg: register offsets, reset values and the filter-length helper
`include "gpio_debounce_regs.vh"
package gpio_debounce_pkg;
  localparam logic [4:0] ADDR_MASK = `GPIO_DEBOUNCE_MASK;
  localparam logic [4:0] ADDR_PRESC = `GPIO_DEBOUNCE_PRESC;
  localparam logic [4:0] ADDR_FLEN = `GPIO_DEBOUNCE_FLEN;
  localparam logic [4:0] ADDR_RAW = `GPIO_DEBOUNCE_RAW;
  localparam logic [3:0] FLEN_RST = `GPIO_DEBOUNCE_FLEN_RST;
  function automatic logic [3:0] eff_len(input logic [3:0] flen);
    return (flen == 4'd0) ? 4'd1 : flen;
  endfunction
endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: two-flop synchroniser, tick-driven stability filter and bypass mux for one pin
module debounce_chan import gpio_debounce_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic       pin_i,
  input  logic       tick_i,
  input  logic       en_i,
  input  logic [3:0] flen_i,
  output logic       sync_o,
  output logic       db_o
);
  logic meta_q, sync_q, stable_q, stable_d, diff, done;
  logic [3:0] cnt_q, cnt_d, eff;
  always_comb begin
    eff = eff_len(flen_i);
    diff = sync_q != stable_q;
    done = ({1'b0, cnt_q} + 5'd1) >= {1'b0, eff};
    stable_d = (diff && tick_i && done) ? sync_q : stable_q;
    cnt_d = !diff ? 4'd0 : !tick_i ? cnt_q : done ? 4'd0 : cnt_q + 4'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      stable_q <= 1'b0;
      cnt_q <= 4'd0;
    end else begin
      meta_q <= pin_i;
      sync_q <= meta_q;
      stable_q <= stable_d;
      cnt_q <= cnt_d;
    end
  end
  assign sync_o = sync_q;
  assign db_o = en_i ? stable_q : sync_q;
endmodule

// File: rtl/gpio_debounce_regs.vh
// gpio_debounce_regs: CSR offsets and FLEN reset value shared by the RTL and the bench
`ifndef GPIO_DEBOUNCE_REGS_VH
`define GPIO_DEBOUNCE_REGS_VH
`define GPIO_DEBOUNCE_MASK 5'h0
`define GPIO_DEBOUNCE_PRESC 5'h1
`define GPIO_DEBOUNCE_FLEN 5'h2
`define GPIO_DEBOUNCE_RAW 5'h3
`define GPIO_DEBOUNCE_FLEN_RST 4'h3
`endif

// File: rtl/gpio_debounce.sv
// gpio_debounce: per-pin synchroniser and glitch filter with CSR controls
// GPIO_DEBOUNCE_PRESCALER_EN adds the tick prescaler and PRESC register; otherwise tick is constant.
module gpio_debounce import gpio_debounce_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       csr_a,
  input  logic [7:0]       csr_di,
  input  logic             csr_we,
  output logic [7:0]       csr_do,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] in_db
);
  logic [WIDTH-1:0] mask_q, mask_d, sync;
  logic [3:0] flen_q, flen_d;
  logic [7:0] presc_rd;
  logic tick;
`ifdef GPIO_DEBOUNCE_PRESCALER_EN
  logic [7:0] presc_q, presc_d, pcnt_q, pcnt_d;
  logic presc_we;
  always_comb begin
    presc_we = csr_we && csr_a == ADDR_PRESC;
    presc_d = presc_we ? csr_di : presc_q;
    tick = pcnt_q == presc_q;
    pcnt_d = (presc_we || tick) ? 8'd0 : pcnt_q + 8'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= 8'd0;
      pcnt_q <= 8'd0;
    end else begin
      presc_q <= presc_d;
      pcnt_q <= pcnt_d;
    end
  end
  assign presc_rd = presc_q;
`else
  assign tick = 1'b1;
  assign presc_rd = 8'h00;
`endif
  always_comb begin
    mask_d = (csr_we && csr_a == ADDR_MASK) ? csr_di[WIDTH-1:0] : mask_q;
    flen_d = (csr_we && csr_a == ADDR_FLEN) ? csr_di[3:0] : flen_q;
    csr_do = csr_a == ADDR_MASK  ? 8'(mask_q) :
             csr_a == ADDR_PRESC ? presc_rd :
             csr_a == ADDR_FLEN  ? {4'h0, flen_q} :
             csr_a == ADDR_RAW   ? 8'(sync) : 8'h00;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
      flen_q <= FLEN_RST;
    end else begin
      mask_q <= mask_d;
      flen_q <= flen_d;
    end
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_chan u_chan (
      .clk   (clk),
      .rst   (rst),
      .pin_i (pin[i]),
      .tick_i(tick),
      .en_i  (mask_q[i]),
      .flen_i(flen_q),
      .sync_o(sync[i]),
      .db_o  (in_db[i])
    );
  end
endmodule

// File: tb/tb_gpio_debounce.sv
// tb_gpio_debounce: directed and randomized checks of gpio_debounce against a tick-counting model
module tb_gpio_debounce;
  import gpio_debounce_pkg::*;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, csr_we = 1'b0;
  logic [4:0] csr_a = 5'h0;
  logic [7:0] csr_di = 8'h00, csr_do, rv;
  logic [W-1:0] pin = '0, in_db;
  int n_vec = 0, n_err = 0;
  logic [W-1:0] m_s1, m_s2, m_stable, m_mask;
  logic [7:0] m_presc;
  logic [3:0] m_flen;
  int m_run[W];
  int m_t;

  always #5 clk = ~clk;

  gpio_debounce #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
    .csr_do(csr_do), .pin(pin), .in_db(in_db)
  );

  function automatic logic [W-1:0] m_out();
    return (m_mask & m_stable) | (~m_mask & m_s2);
  endfunction

  // advance one clock edge; the model counts consecutive ticks a channel has disagreed
  task automatic cyc();
    bit tk;
    int eff;
    eff = (m_flen == 4'd0) ? 1 : int'(m_flen);
`ifdef GPIO_DEBOUNCE_PRESCALER_EN
    tk = (m_t % (int'(m_presc) + 1)) == int'(m_presc);
`else
    tk = 1'b1;
`endif
    @(posedge clk);
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_mask = '0;
      m_presc = 8'h00; m_flen = FLEN_RST; m_t = 0;
      for (int c = 0; c < W; c++) m_run[c] = 0;
    end else begin
      for (int c = 0; c < W; c++) begin
        if (m_s2[c] != m_stable[c]) begin
          if (tk) begin
            m_run[c]++;
            if (m_run[c] >= eff) begin
              m_stable[c] = m_s2[c];
              m_run[c] = 0;
            end
          end
        end else m_run[c] = 0;
      end
      m_s2 = m_s1;
      m_s1 = pin;
      m_t++;
      if (csr_we) begin
        if (csr_a == ADDR_MASK) m_mask = csr_di;
        if (csr_a == ADDR_FLEN) m_flen = csr_di[3:0];
`ifdef GPIO_DEBOUNCE_PRESCALER_EN
        if (csr_a == ADDR_PRESC) begin
          m_presc = csr_di;
          m_t = 0;
        end
`endif
      end
    end
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    csr_a = a; csr_di = d; csr_we = 1'b1;
    cyc();
    csr_we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] d);
    csr_a = a;
    #1;
    d = csr_do;
  endtask

  task automatic do_reset();
    rst = 1'b1; csr_we = 1'b0; pin = '0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rd(ADDR_MASK, rv); n_vec++;
    if (rv !== 8'h00) begin n_err++; $display("FAIL reset_mask got=%h exp=00", rv); end
    rd(ADDR_PRESC, rv); n_vec++;
    if (rv !== 8'h00) begin n_err++; $display("FAIL reset_presc got=%h exp=00", rv); end
    rd(ADDR_FLEN, rv); n_vec++;
    if (rv !== 8'h03) begin n_err++; $display("FAIL reset_flen got=%h exp=03", rv); end
    n_vec++;
    if (in_db !== 8'h00) begin n_err++; $display("FAIL reset_in_db got=%h exp=00", in_db); end
  endtask

  task automatic test_bypass();
    wr(ADDR_MASK, 8'h00);
    pin = 8'hA5;
    cyc(); n_vec++;
    if (in_db !== 8'h00) begin n_err++; $display("FAIL bypass_early got=%h exp=00", in_db); end
    cyc(); n_vec++;
    if (in_db !== 8'hA5) begin n_err++; $display("FAIL bypass_2edge got=%h exp=a5", in_db); end
    rd(ADDR_RAW, rv); n_vec++;
    if (rv !== 8'hA5) begin n_err++; $display("FAIL bypass_raw got=%h exp=a5", rv); end
  endtask

  task automatic test_filter();
    wr(ADDR_MASK, 8'hFF); wr(ADDR_FLEN, 8'h03); wr(ADDR_PRESC, 8'h00);
    pin = 8'h00;
    repeat (12) cyc();
    pin = 8'h01;
    for (int k = 1; k <= 5; k++) begin
      cyc(); n_vec++;
      if (in_db !== ((k == 5) ? 8'h01 : 8'h00)) begin
        n_err++; $display("FAIL filter_edge%0d got=%h exp=%h", k, in_db, (k == 5) ? 8'h01 : 8'h00);
      end
    end
  endtask

  task automatic test_glitch();
    pin = 8'h00;
    repeat (12) cyc();
    pin = 8'h01;
    cyc(); cyc();
    pin = 8'h00;
    for (int k = 0; k < 20; k++) begin
      cyc(); n_vec++;
      if (in_db !== 8'h00) begin n_err++; $display("FAIL glitch_cyc%0d got=%h exp=00", k, in_db); end
    end
  endtask

  task automatic test_prescale();
    int n;
    wr(ADDR_PRESC, 8'd9); wr(ADDR_FLEN, 8'd2);
    pin = 8'h80;
    n = 0;
    while (in_db !== 8'h80 && n < 40) begin
      cyc();
      n++;
    end
`ifdef GPIO_DEBOUNCE_PRESCALER_EN
    n_vec++;
    if (n < 13 || n > 22) begin n_err++; $display("FAIL prescale_latency got=%0d exp=13..22", n); end
    rd(ADDR_PRESC, rv); n_vec++;
    if (rv !== 8'd9) begin n_err++; $display("FAIL prescale_presc got=%h exp=09", rv); end
`else
    n_vec++;
    if (n != 4) begin n_err++; $display("FAIL prescale_latency got=%0d exp=4", n); end
    rd(ADDR_PRESC, rv); n_vec++;
    if (rv !== 8'h00) begin n_err++; $display("FAIL prescale_presc got=%h exp=00", rv); end
`endif
  endtask

  task automatic test_decode();
    wr(5'h07, 8'h55);
    rd(5'h07, rv); n_vec++;
    if (rv !== 8'h00) begin n_err++; $display("FAIL decode_rd7 got=%h exp=00", rv); end
    rd(ADDR_MASK, rv); n_vec++;
    if (rv !== m_mask) begin n_err++; $display("FAIL decode_mask got=%h exp=%h", rv, m_mask); end
    rd(ADDR_PRESC, rv); n_vec++;
    if (rv !== m_presc) begin n_err++; $display("FAIL decode_presc got=%h exp=%h", rv, m_presc); end
    rd(ADDR_FLEN, rv); n_vec++;
    if (rv !== {4'h0, m_flen}) begin n_err++; $display("FAIL decode_flen got=%h exp=%h", rv, m_flen); end
  endtask

  task automatic test_reset_mid();
    wr(ADDR_MASK, 8'hFF); wr(ADDR_FLEN, 8'h05);
    pin = 8'h3C;
    repeat (4) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_vec++;
    if (in_db !== 8'h00) begin n_err++; $display("FAIL midreset_in_db got=%h exp=00", in_db); end
    rd(ADDR_RAW, rv); n_vec++;
    if (rv !== 8'h00) begin n_err++; $display("FAIL midreset_raw got=%h exp=00", rv); end
    rd(ADDR_MASK, rv); n_vec++;
    if (rv !== 8'h00) begin n_err++; $display("FAIL midreset_mask got=%h exp=00", rv); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      do_reset();
      wr(ADDR_MASK, 8'($urandom));
      wr(ADDR_FLEN, 8'($urandom_range(0, 4)));
      wr(ADDR_PRESC, 8'($urandom_range(0, 3)));
      for (int k = 0; k < 250; k++) begin
        if ($urandom_range(0, 5) == 0) pin = pin ^ W'($urandom);
        if (k == 125) wr(ADDR_FLEN, 8'($urandom_range(0, 4)));
        else cyc();
        rd(ADDR_RAW, rv);
        n_vec++;
        if (in_db !== m_out()) begin
          n_err++; $display("FAIL random_in_db r=%0d k=%0d got=%h exp=%h", r, k, in_db, m_out());
        end
        n_vec++;
        if (rv !== m_s2) begin
          n_err++; $display("FAIL random_raw r=%0d k=%0d got=%h exp=%h", r, k, rv, m_s2);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_filter();
    test_glitch();
    test_prescale();
    test_decode();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
